// File: rtl/data_sram_resp_pkg.sv
// Shared width/base constants and the address-window helper for the data SRAM.
package data_sram_resp_pkg;

  localparam int          DSRAM_ADDR_W = 12;
  localparam logic [31:0] DSRAM_BASE   = 32'h1c00_0000;

  // True when addr falls in the 2^(aw+2)-byte window starting at base.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          aw);
    return (addr >> (aw + 2)) == (base >> (aw + 2));
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM access bus: the CPU side drives requests, the SRAM returns read data.
interface data_sram_resp_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/dsram_perf_cnt.sv
// Wrapping 32-bit event counter; compiled only when DSRAM_PERF_CNT_EN is defined.
`ifdef DSRAM_PERF_CNT_EN
module dsram_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt = r_cnt;

endmodule
`endif

// File: rtl/data_sram_resp.sv
// Single-port data SRAM window with 1-cycle read, sticky range-error capture and
// optional access counters (DSRAM_PERF_CNT_EN).
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = DSRAM_ADDR_W,
  parameter logic [31:0] BASE_ADDR = DSRAM_BASE
) (
  input  logic                   clk,
  input  logic                   reset,
  data_sram_resp_if.slave        bus,
  input  logic                   err_clr,
  output logic                   access_err,
  output logic [31:0]            err_addr,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic              r_access_err;
  logic [31:0]       r_err_addr;

  logic              w_in_win;
  logic              w_is_rd;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_err;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused;

  assign w_in_win = in_window(bus.data_sram_addr, BASE_ADDR, ADDR_W);
  assign w_idx    = bus.data_sram_addr[ADDR_W+1:2];
  assign w_unused = ^bus.data_sram_addr[1:0];
  assign w_is_rd  = (bus.data_sram_wen == 4'h0);
  assign w_err    = bus.data_sram_en && !w_in_win;
  assign w_rd_ok  = bus.data_sram_en && w_in_win && w_is_rd;
  assign w_wr_ok  = bus.data_sram_en && w_in_win && !w_is_rd;

  // Memory words are not cleared by reset; sharing the block just blocks writes while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata      <= '0;
      r_access_err <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      if (w_wr_ok) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.data_sram_wen[i]) begin
            r_mem[w_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
          end
        end
      end

      if (w_rd_ok) begin
        r_rdata <= r_mem[w_idx];
      end else if (w_err && w_is_rd) begin
        r_rdata <= '0;
      end

      // A new error beats a simultaneous clear and re-arms the address capture.
      if (w_err) begin
        r_access_err <= 1'b1;
        if (!r_access_err || err_clr) begin
          r_err_addr <= bus.data_sram_addr;
        end
      end else if (err_clr) begin
        r_access_err <= 1'b0;
        r_err_addr   <= '0;
      end
    end
  end

  assign bus.data_sram_rdata = r_rdata;
  assign access_err          = r_access_err;
  assign err_addr            = r_err_addr;

`ifdef DSRAM_PERF_CNT_EN
  dsram_perf_cnt u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_rd_ok),
    .cnt   (rd_cnt)
  );

  dsram_perf_cnt u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wr_ok),
    .cnt   (wr_cnt)
  );
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
